// File: rtl/trng_pmf_pkg.sv
// rtl/trng_pmf_pkg.sv - shared types and constants for the PMF table arbiter
package trng_pmf_pkg;

    localparam int PMF_DW = 14;

    // Which requester issued a given table lookup
    typedef enum logic {
        OWN_AC  = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

    // Arbiter states: AC normally wins, CPU_FORCE lets a starved CPU through
    typedef enum logic {
        AC_PRIO   = 1'b0,
        CPU_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/trng_pmf_tag_pipe.sv
// rtl/trng_pmf_tag_pipe.sv - RD_LAT-deep {valid, owner} tag shift register with AC flush
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   issue_valid, issue_owner tag entering the pipe (one per granted lookup)
//   flush_ac                 drops every in-flight AC tag, including the one at the tail
//   tail_valid, tail_owner   tag whose table data is on pmf_data_out this cycle
// Macro PMF_CPU_PORT_EN: when undefined only the valid bit is stored and every tag is AC.
module trng_pmf_tag_pipe
    import trng_pmf_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   issue_valid,
    input  owner_e issue_owner,
    input  logic   flush_ac,
    output logic   tail_valid,
    output owner_e tail_owner
);

    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] ac_own;   // 1 = stage belongs to the AC requester

`ifdef PMF_CPU_PORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac_own <= '1;
        end else begin
            ac_own[0] <= (issue_owner == OWN_AC);
            for (int i = 1; i < RD_LAT; i++) begin
                ac_own[i] <= ac_own[i-1];
            end
        end
    end
`else
    logic unused_owner;
    assign unused_owner = issue_owner;
    assign ac_own       = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= issue_valid & ~(flush_ac & (issue_owner == OWN_AC));
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1] & ~(flush_ac & ac_own[i-1]);
            end
        end
    end

    // An AC tag at the tail during a flush is suppressed before capture
    assign tail_valid = vld[RD_LAT-1] & ~(flush_ac & ac_own[RD_LAT-1]);
    assign tail_owner = ac_own[RD_LAT-1] ? OWN_AC : OWN_CPU;

endmodule

// File: rtl/trng_pmf_arbiter.sv
// rtl/trng_pmf_arbiter.sv - arbiter/sequencer for the shared TRNG PMF lookup table
//
// Ports:
//   rng_clk, rst               clock, asynchronous active-high reset
//   rst_trng_logic             synchronous flush of autocorrelation traffic
//   ac_req/ac_addr/ac_gnt      autocorrelation request (gnt combinational)
//   ac_rvalid/ac_rdata         autocorrelation response
//   cpu_req/cpu_addr/cpu_gnt   CPU request (gnt combinational)
//   cpu_rvalid/cpu_rdata       CPU response
//   pmf_en/pmf_addr            table read port, pmf_data_out returns RD_LAT cycles later
//   cpu_stall_cnt              saturating count of cycles the CPU lost arbitration
// Macro PMF_CPU_PORT_EN: enables the CPU port, FSM, wait counter and stall counter.
module trng_pmf_arbiter
    import trng_pmf_pkg::*;
#(
    parameter int AW           = 8,
    parameter int RD_LAT       = 1,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic              rng_clk,
    input  logic              rst,
    input  logic              rst_trng_logic,
    input  logic              ac_req,
    input  logic [AW-1:0]     ac_addr,
    output logic              ac_gnt,
    output logic              ac_rvalid,
    output logic [PMF_DW-1:0] ac_rdata,
    input  logic              cpu_req,
    input  logic [AW-1:0]     cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [PMF_DW-1:0] cpu_rdata,
    output logic              pmf_en,
    output logic [AW-1:0]     pmf_addr,
    input  logic [PMF_DW-1:0] pmf_data_out,
    output logic [7:0]        cpu_stall_cnt
);

    logic [AW-1:0] addr_q;
    logic          issue_valid;
    owner_e        issue_owner;
    logic          tail_valid;
    owner_e        tail_owner;

`ifdef PMF_CPU_PORT_EN
    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    arb_state_e        state, state_next;
    logic [3:0]        wait_cnt, wait_next;
    logic              stall;
    logic [7:0]        stall_cnt;
    logic              cpu_rvalid_q;
    logic [PMF_DW-1:0] cpu_rdata_q;

    always_ff @(posedge rng_clk or posedge rst) begin
        if (rst) state <= AC_PRIO;
        else     state <= state_next;
    end

    // Forcing is decided on the cycle the counter reaches the limit, so the
    // CPU wins on the very next cycle rather than one later.
    always_comb begin
        state_next = state;
        case (state)
            AC_PRIO:   if (stall && wait_next == MAX_WAIT) state_next = CPU_FORCE;
            CPU_FORCE: state_next = AC_PRIO;
            default:   state_next = AC_PRIO;
        endcase
    end

    // Grants are held low while rst is asserted so outputs match reset values
    always_comb begin
        ac_gnt  = 1'b0;
        cpu_gnt = 1'b0;
        if (!rst) begin
            case (state)
                AC_PRIO: begin
                    ac_gnt  = ac_req & ~rst_trng_logic;
                    cpu_gnt = cpu_req & ~ac_req;
                end
                CPU_FORCE: cpu_gnt = cpu_req;
                default: ;
            endcase
        end
    end

    assign stall = cpu_req & ~cpu_gnt;

    always_comb begin
        wait_next = 4'd0;
        if (stall) wait_next = (wait_cnt >= MAX_WAIT) ? MAX_WAIT : wait_cnt + 4'd1;
    end

    always_ff @(posedge rng_clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            stall_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_next;
            if (stall && stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
        end
    end

    always_ff @(posedge rng_clk or posedge rst) begin
        if (rst) begin
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= tail_valid & (tail_owner == OWN_CPU);
            if (tail_valid && tail_owner == OWN_CPU) cpu_rdata_q <= pmf_data_out;
        end
    end

    assign cpu_stall_cnt = stall_cnt;
    assign cpu_rvalid    = cpu_rvalid_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign issue_owner   = cpu_gnt ? OWN_CPU : OWN_AC;
`else
    logic unused_cpu;
    assign unused_cpu    = ^{cpu_req, tail_owner};
    assign ac_gnt        = ac_req & ~rst_trng_logic & ~rst;
    assign cpu_gnt       = 1'b0;
    assign cpu_rvalid    = 1'b0;
    assign cpu_rdata     = '0;
    assign cpu_stall_cnt = 8'd0;
    assign issue_owner   = OWN_AC;
`endif

    assign issue_valid = ac_gnt | cpu_gnt;
    assign pmf_en      = issue_valid;
    assign pmf_addr    = ac_gnt ? ac_addr : (cpu_gnt ? cpu_addr : addr_q);

    always_ff @(posedge rng_clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= pmf_addr;
    end

    trng_pmf_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk         (rng_clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_owner (issue_owner),
        .flush_ac    (rst_trng_logic),
        .tail_valid  (tail_valid),
        .tail_owner  (tail_owner)
    );

    always_ff @(posedge rng_clk or posedge rst) begin
        if (rst) begin
            ac_rvalid <= 1'b0;
            ac_rdata  <= '0;
        end else begin
            ac_rvalid <= tail_valid & (tail_owner == OWN_AC);
            if (tail_valid && tail_owner == OWN_AC) ac_rdata <= pmf_data_out;
        end
    end

endmodule

// File: tb/tb_trng_pmf_arbiter.sv
// tb/tb_trng_pmf_arbiter.sv - scoreboard testbench for trng_pmf_arbiter
module tb_trng_pmf_arbiter;

    localparam int AW     = 8;
    localparam int RD_LAT = 3;
    localparam int MAXW   = 4;

    logic          rng_clk;
    logic          rst;
    logic          rst_trng_logic;
    logic          ac_req;
    logic [AW-1:0] ac_addr;
    logic          ac_gnt;
    logic          ac_rvalid;
    logic [13:0]   ac_rdata;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [13:0]   cpu_rdata;
    logic          pmf_en;
    logic [AW-1:0] pmf_addr;
    logic [13:0]   pmf_data_out;
    logic [7:0]    cpu_stall_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ac_rv_cnt = 0;
    int cpu_rv_cnt = 0;

    typedef struct {
        int          due;
        logic [13:0] data;
    } exp_t;
    exp_t acq[$];
    exp_t cpuq[$];

    trng_pmf_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .CPU_MAX_WAIT(MAXW)) dut (
        .rng_clk        (rng_clk),
        .rst            (rst),
        .rst_trng_logic (rst_trng_logic),
        .ac_req         (ac_req),
        .ac_addr        (ac_addr),
        .ac_gnt         (ac_gnt),
        .ac_rvalid      (ac_rvalid),
        .ac_rdata       (ac_rdata),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_gnt        (cpu_gnt),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_rdata      (cpu_rdata),
        .pmf_en         (pmf_en),
        .pmf_addr       (pmf_addr),
        .pmf_data_out   (pmf_data_out),
        .cpu_stall_cnt  (cpu_stall_cnt)
    );

    function automatic logic [13:0] tbl(input logic [7:0] a);
        return 14'h100 + {6'd0, a};
    endfunction

    initial rng_clk = 1'b0;
    always #5 rng_clk = ~rng_clk;

    always @(posedge rng_clk) cyc++;

    // Table model: synchronous read, data valid RD_LAT cycles after the address
    logic [13:0] tp [RD_LAT];
    always @(posedge rng_clk) begin
        tp[0] <= tbl(pmf_addr);
        for (int i = 1; i < RD_LAT; i++) tp[i] <= tp[i-1];
    end
    assign pmf_data_out = tp[RD_LAT-1];

    always @(posedge rst) begin
        acq.delete();
        cpuq.delete();
    end

    // Scoreboard monitor: grants push expectations, rvalids pop and compare
    always @(negedge rng_clk) begin
        if (!rst) begin
            if (ac_rvalid) begin
                exp_t e;
                ac_rv_cnt++;
                checks++;
                if (acq.size() == 0) begin
                    errors++;
                    $display("FAIL ac_resp_unexpected cycle=%0d data=%h", cyc, ac_rdata);
                end else begin
                    e = acq.pop_front();
                    if (ac_rdata !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL ac_resp got data=%h cycle=%0d, expected data=%h cycle=%0d",
                                 ac_rdata, cyc, e.data, e.due);
                    end
                end
            end
            if (cpu_rvalid) begin
                exp_t e;
                cpu_rv_cnt++;
                checks++;
                if (cpuq.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_resp_unexpected cycle=%0d data=%h", cyc, cpu_rdata);
                end else begin
                    e = cpuq.pop_front();
                    if (cpu_rdata !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL cpu_resp got data=%h cycle=%0d, expected data=%h cycle=%0d",
                                 cpu_rdata, cyc, e.data, e.due);
                    end
                end
            end
            if (rst_trng_logic) acq.delete();
            if (ac_gnt === 1'b1)  acq.push_back('{cyc + RD_LAT + 1, tbl(ac_addr)});
            if (cpu_gnt === 1'b1) cpuq.push_back('{cyc + RD_LAT + 1, tbl(cpu_addr)});
        end
    end

    task automatic step();
        @(posedge rng_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge rng_clk);
    endtask

    task automatic test_reset();
        sample();
        checks++;
        if ({ac_gnt, cpu_gnt, ac_rvalid, cpu_rvalid, pmf_en} !== 5'b0 ||
            ac_rdata !== 14'd0 || cpu_rdata !== 14'd0 ||
            pmf_addr !== 8'd0 || cpu_stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_values got gnt=%b%b rv=%b%b en=%b ad=%h acd=%h cpd=%h st=%h, expected all 0",
                     ac_gnt, cpu_gnt, ac_rvalid, cpu_rvalid, pmf_en, pmf_addr, ac_rdata, cpu_rdata, cpu_stall_cnt);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_ac_stream();
        int base = ac_rv_cnt;
        for (int i = 0; i < 16; i++) begin
            step();
            ac_req  = 1'b1;
            ac_addr = 8'(i);
            sample();
            checks++;
            if (ac_gnt !== 1'b1 || pmf_en !== 1'b1 || pmf_addr !== 8'(i)) begin
                errors++;
                $display("FAIL ac_stream_gnt i=%0d got gnt=%b en=%b addr=%h, expected 1 1 %h",
                         i, ac_gnt, pmf_en, pmf_addr, 8'(i));
            end
        end
        step();
        ac_req  = 1'b0;
        ac_addr = 8'hAA;
        sample();
        checks++;
        if (pmf_en !== 1'b0 || pmf_addr !== 8'h0F) begin
            errors++;
            $display("FAIL pmf_addr_hold got en=%b addr=%h, expected 0 0f", pmf_en, pmf_addr);
        end
        repeat (RD_LAT + 3) step();
        checks++;
        if (ac_rv_cnt - base != 16) begin
            errors++;
            $display("FAIL ac_stream_count got %0d, expected 16", ac_rv_cnt - base);
        end
    endtask

`ifdef PMF_CPU_PORT_EN
    task automatic test_starvation();
        for (int k = 1; k <= 10; k++) begin
            logic exp_cpu;
            step();
            ac_req   = 1'b1;
            ac_addr  = 8'(8'h30 + k);
            cpu_req  = 1'b1;
            cpu_addr = 8'(8'h80 + k);
            sample();
            exp_cpu = (k % 5 == 0);
            checks++;
            if (cpu_gnt !== exp_cpu || ac_gnt !== !exp_cpu) begin
                errors++;
                $display("FAIL starve_gnt k=%0d got cpu=%b ac=%b, expected cpu=%b ac=%b",
                         k, cpu_gnt, ac_gnt, exp_cpu, !exp_cpu);
            end
        end
        step();
        ac_req  = 1'b0;
        cpu_req = 1'b0;
        sample();
        checks++;
        if (cpu_stall_cnt !== 8'd8) begin
            errors++;
            $display("FAIL stall_cnt_10 got %0d, expected 8", cpu_stall_cnt);
        end
        repeat (RD_LAT + 3) step();
    endtask

    task automatic test_interleave();
        int ab = ac_rv_cnt;
        int cb = cpu_rv_cnt;
        for (int r = 0; r < 2; r++) begin
            step();
            ac_req   = 1'b1;
            ac_addr  = 8'h11;
            step();
            ac_req   = 1'b0;
            cpu_req  = 1'b1;
            cpu_addr = 8'h22;
            step();
            cpu_req  = 1'b0;
        end
        repeat (RD_LAT + 3) step();
        sample();
        checks++;
        if (ac_rdata !== tbl(8'h11) || cpu_rdata !== tbl(8'h22)) begin
            errors++;
            $display("FAIL interleave_data got ac=%h cpu=%h, expected %h %h",
                     ac_rdata, cpu_rdata, tbl(8'h11), tbl(8'h22));
        end
        checks++;
        if (ac_rv_cnt - ab != 2 || cpu_rv_cnt - cb != 2) begin
            errors++;
            $display("FAIL interleave_count got ac=%0d cpu=%0d, expected 2 2",
                     ac_rv_cnt - ab, cpu_rv_cnt - cb);
        end
    endtask
`endif

    task automatic test_flush();
        int ab = ac_rv_cnt;
        int cb = cpu_rv_cnt;
        int exp_cpu = 0;
        step();
`ifdef PMF_CPU_PORT_EN
        cpu_req  = 1'b1;
        cpu_addr = 8'h50;
        exp_cpu  = 1;
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            cpu_req = 1'b0;
            ac_req  = 1'b1;
            ac_addr = 8'(8'h40 + i);
        end
        step();
        rst_trng_logic = 1'b1;
        ac_addr        = 8'h43;
        sample();
        checks++;
        if (ac_gnt !== 1'b0) begin
            errors++;
            $display("FAIL flush_gnt got %b, expected 0", ac_gnt);
        end
        step();
        rst_trng_logic = 1'b0;
        ac_req         = 1'b0;
        repeat (RD_LAT + 3) step();
        checks++;
        if (ac_rv_cnt - ab != 0 || cpu_rv_cnt - cb != exp_cpu) begin
            errors++;
            $display("FAIL flush_count got ac=%0d cpu=%0d, expected 0 %0d",
                     ac_rv_cnt - ab, cpu_rv_cnt - cb, exp_cpu);
        end
    endtask

`ifdef PMF_CPU_PORT_EN
    task automatic test_saturation();
        step();
        ac_req   = 1'b1;
        ac_addr  = 8'h05;
        cpu_req  = 1'b1;
        cpu_addr = 8'h06;
        repeat (404) step();
        sample();
        checks++;
        if (cpu_gnt !== 1'b1 || ac_gnt !== 1'b0 || cpu_stall_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL saturate got cpu=%b ac=%b st=%h, expected 1 0 ff",
                     cpu_gnt, ac_gnt, cpu_stall_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ac_gnt, cpu_gnt, ac_rvalid, cpu_rvalid, pmf_en} !== 5'b0 ||
            ac_rdata !== 14'd0 || cpu_rdata !== 14'd0 ||
            pmf_addr !== 8'd0 || cpu_stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL sat_rst_outputs got gnt=%b%b rv=%b%b en=%b ad=%h st=%h, expected all 0",
                     ac_gnt, cpu_gnt, ac_rvalid, cpu_rvalid, pmf_en, pmf_addr, cpu_stall_cnt);
        end
        step();
        rst = 1'b0;
        sample();
        checks++;
        if (ac_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL sat_rst_fsm got ac=%b cpu=%b, expected 1 0", ac_gnt, cpu_gnt);
        end
        step();
        ac_req  = 1'b0;
        cpu_req = 1'b0;
        repeat (RD_LAT + 3) step();
    endtask
`else
    task automatic test_macro_off();
        int cb = cpu_rv_cnt;
        for (int k = 1; k <= 10; k++) begin
            step();
            ac_req   = 1'b1;
            ac_addr  = 8'(8'h60 + k);
            cpu_req  = 1'b1;
            cpu_addr = 8'h90;
            sample();
            checks++;
            if (ac_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_stall_cnt !== 8'd0 || cpu_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL macro_off k=%0d got ac=%b cpu=%b st=%h crv=%b, expected 1 0 00 0",
                         k, ac_gnt, cpu_gnt, cpu_stall_cnt, cpu_rvalid);
            end
        end
        step();
        ac_req  = 1'b0;
        cpu_req = 1'b0;
        repeat (RD_LAT + 3) step();
        checks++;
        if (cpu_rv_cnt != cb) begin
            errors++;
            $display("FAIL macro_off_cpu_rv got %0d, expected 0", cpu_rv_cnt - cb);
        end
    endtask
`endif

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            ac_req  = 1'b1;
            ac_addr = 8'(8'hC0 + i);
        end
        sample();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ac_gnt, cpu_gnt, ac_rvalid, cpu_rvalid, pmf_en} !== 5'b0 ||
            ac_rdata !== 14'd0 || pmf_addr !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset got gnt=%b%b rv=%b%b en=%b ad=%h acd=%h, expected all 0",
                     ac_gnt, cpu_gnt, ac_rvalid, cpu_rvalid, pmf_en, pmf_addr, ac_rdata);
        end
        step();
        ac_req = 1'b0;
        rst    = 1'b0;
        repeat (RD_LAT + 3) step();
    endtask

    initial begin
        rst            = 1'b1;
        rst_trng_logic = 1'b0;
        ac_req         = 1'b0;
        ac_addr        = '0;
        cpu_req        = 1'b0;
        cpu_addr       = '0;
        test_reset();
        test_ac_stream();
`ifdef PMF_CPU_PORT_EN
        test_starvation();
        test_interleave();
`endif
        test_flush();
`ifdef PMF_CPU_PORT_EN
        test_saturation();
`else
        test_macro_off();
`endif
        test_mid_reset();
        checks++;
        if (acq.size() != 0 || cpuq.size() != 0) begin
            errors++;
            $display("FAIL drain got ac=%0d cpu=%0d pending, expected 0 0", acq.size(), cpuq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
